// File: rtl/triangle_dispatcher.sv
// Buffers incoming triangles in a small FIFO and issues them one at a time to a pixel core.
// Optional zero-area culling is enabled by defining TRI_DISPATCH_CULL_EN.
module triangle_dispatcher #(
  parameter int COORD_WIDTH = 16,
  parameter int COLOR_WIDTH = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [2:0][2:0][COORD_WIDTH-1:0]    in_bounds,
  input  logic [COLOR_WIDTH-1:0]              in_color,
  output logic                                start,
  output logic [2:0][2:0][COORD_WIDTH-1:0]    bounds,
  output logic [COLOR_WIDTH-1:0]              color,
  input  logic                                eoc,
  output logic                                busy,
`ifdef TRI_DISPATCH_CULL_EN
  output logic [COUNT_WIDTH-1:0]              culled_count,
`endif
  output logic [COUNT_WIDTH-1:0]              done_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                             state;
  logic [PW-1:0]                      wr_ptr, rd_ptr;
  logic [2:0][2:0][COORD_WIDTH-1:0]   mem_bounds [FIFO_DEPTH];
  logic [COLOR_WIDTH-1:0]             mem_color  [FIFO_DEPTH];
  logic                               fifo_empty, fifo_full, push, pop;
  logic [2:0][2:0][COORD_WIDTH-1:0]   head_bounds;
  logic [COLOR_WIDTH-1:0]             head_color;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready    = !fifo_full;
  assign push        = in_valid && in_ready;
  assign pop         = (state == IDLE) && !fifo_empty;
  assign head_bounds = mem_bounds[rd_ptr[AW-1:0]];
  assign head_color  = mem_color[rd_ptr[AW-1:0]];
  assign busy        = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_bounds[wr_ptr[AW-1:0]] <= in_bounds;
      mem_color[wr_ptr[AW-1:0]]  <= in_color;
    end
  end

`ifdef TRI_DISPATCH_CULL_EN
  // Doubled signed area of the head triangle; zero means degenerate (collinear or coincident).
  logic signed [COORD_WIDTH:0]       dx1, dy1, dx2, dy2;
  logic signed [2*COORD_WIDTH+2:0]   prod_a, prod_b, area;
  logic                              cull;

  assign dx1    = $signed({head_bounds[1][0][COORD_WIDTH-1], head_bounds[1][0]})
                - $signed({head_bounds[0][0][COORD_WIDTH-1], head_bounds[0][0]});
  assign dy1    = $signed({head_bounds[1][1][COORD_WIDTH-1], head_bounds[1][1]})
                - $signed({head_bounds[0][1][COORD_WIDTH-1], head_bounds[0][1]});
  assign dx2    = $signed({head_bounds[2][0][COORD_WIDTH-1], head_bounds[2][0]})
                - $signed({head_bounds[0][0][COORD_WIDTH-1], head_bounds[0][0]});
  assign dy2    = $signed({head_bounds[2][1][COORD_WIDTH-1], head_bounds[2][1]})
                - $signed({head_bounds[0][1][COORD_WIDTH-1], head_bounds[0][1]});
  assign prod_a = dx1 * dy2;
  assign prod_b = dx2 * dy1;
  assign area   = prod_a - prod_b;
  assign cull   = (area == '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      start      <= 1'b0;
      bounds     <= '0;
      color      <= '0;
      done_count <= '0;
`ifdef TRI_DISPATCH_CULL_EN
      culled_count <= '0;
`endif
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
`ifdef TRI_DISPATCH_CULL_EN
            if (cull) culled_count <= culled_count + COUNT_WIDTH'(1);
            else
`endif
            begin
              bounds <= head_bounds;
              color  <= head_color;
              start  <= 1'b1;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (eoc) begin
            done_count <= done_count + COUNT_WIDTH'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Randomized bench for triangle_dispatcher, checked every cycle against a queue-based reference model.
module tb_triangle_dispatcher;
  localparam int CW = 16, KW = 16, DEPTH = 4, NW = 32;

  typedef logic [2:0][2:0][CW-1:0] bnd_t;
  typedef struct packed { bnd_t b; logic [KW-1:0] c; } tri_t;

  logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0, eoc = 1'b0;
  logic          in_ready, start, busy;
  bnd_t          in_bounds = '0, bounds;
  logic [KW-1:0] in_color = '0, color;
  logic [NW-1:0] done_count;
`ifdef TRI_DISPATCH_CULL_EN
  logic [NW-1:0] culled_count;
`endif

  triangle_dispatcher #(.COORD_WIDTH(CW), .COLOR_WIDTH(KW), .FIFO_DEPTH(DEPTH), .COUNT_WIDTH(NW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_bounds(in_bounds), .in_color(in_color), .start(start), .bounds(bounds),
    .color(color), .eoc(eoc), .busy(busy),
`ifdef TRI_DISPATCH_CULL_EN
    .culled_count(culled_count),
`endif
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  // Reference model: pending triangles, whether one is out at the core, and the cycle it was issued.
  tri_t          q[$];
  bit            inflight = 0;
  int            issue_cyc = 0;
  bit            m_start = 0;
  bnd_t          m_bounds = '0;
  logic [KW-1:0] m_color = '0;
  logic [NW-1:0] m_done = '0, m_culled = '0;

  task automatic checkOutput(input string tag, input logic [191:0] got, input logic [191:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  function automatic bit zeroArea(input tri_t t);
    longint x0, y0, x1, y1, x2, y2;
    x0 = longint'($signed(t.b[0][0])); y0 = longint'($signed(t.b[0][1]));
    x1 = longint'($signed(t.b[1][0])); y1 = longint'($signed(t.b[1][1]));
    x2 = longint'($signed(t.b[2][0])); y2 = longint'($signed(t.b[2][1]));
    return ((x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0)) == 0;
  endfunction

  function automatic bit isCulled(input tri_t t);
`ifdef TRI_DISPATCH_CULL_EN
    return zeroArea(t);
`else
    return (t.c !== t.c);
`endif
  endfunction

  // Advance the model by one rising edge using the inputs that were present before it.
  task automatic modelEdge();
    bit   accept;
    tri_t t;
    m_start = 0;
    if (reset) begin
      q.delete();
      inflight = 0;
      m_bounds = '0; m_color = '0; m_done = '0; m_culled = '0;
      return;
    end
    accept = in_valid && (q.size() < DEPTH);
    if (!inflight && q.size() > 0) begin
      t = q.pop_front();
      if (isCulled(t)) m_culled++;
      else begin
        inflight = 1; issue_cyc = cyc;
        m_bounds = t.b; m_color = t.c; m_start = 1;
      end
    end else if (inflight && cyc >= issue_cyc + 2 && eoc) begin
      inflight = 0;
      m_done++;
    end
    if (accept) q.push_back('{b: in_bounds, c: in_color});
  endtask

  task automatic applyStimulus(input logic v, input tri_t t, input logic e, input logic r);
    in_valid = v; in_bounds = t.b; in_color = t.c; eoc = e; reset = r;
    @(posedge clk);
    cyc++;
    modelEdge();
    #1;
    checkOutput("start",      192'(start),      192'(m_start));
    checkOutput("in_ready",   192'(in_ready),   192'(q.size() < DEPTH));
    checkOutput("busy",       192'(busy),       192'(inflight || q.size() > 0));
    checkOutput("bounds",     192'(bounds),     192'(m_bounds));
    checkOutput("color",      192'(color),      192'(m_color));
    checkOutput("done_count", 192'(done_count), 192'(m_done));
`ifdef TRI_DISPATCH_CULL_EN
    checkOutput("culled_count", 192'(culled_count), 192'(m_culled));
`endif
  endtask

  function automatic tri_t mkTri(input int x0, y0, z0, x1, y1, z1, x2, y2, z2, input int c);
    tri_t t;
    t.b[0][0] = CW'(x0); t.b[0][1] = CW'(y0); t.b[0][2] = CW'(z0);
    t.b[1][0] = CW'(x1); t.b[1][1] = CW'(y1); t.b[1][2] = CW'(z1);
    t.b[2][0] = CW'(x2); t.b[2][1] = CW'(y2); t.b[2][2] = CW'(z2);
    t.c = KW'(c);
    return t;
  endfunction

  // Mostly full-range random triangles, with some degenerate ones mixed in.
  function automatic tri_t randTri();
    tri_t t;
    t.b = {$urandom, $urandom, $urandom, $urandom, $urandom};
    t.c = KW'($urandom);
    if ($urandom_range(0, 4) == 0) begin
      t.b[1][0] = t.b[0][0]; t.b[1][1] = t.b[0][1];
    end
    return t;
  endfunction

  tri_t nullTri = '0;

  initial begin
    applyStimulus(0, nullTri, 0, 1);
    applyStimulus(0, nullTri, 0, 1);
    repeat (2) applyStimulus(0, nullTri, 1, 0);

    // Single triangle, long core computation, one eoc.
    applyStimulus(1, mkTri(0, 0, 0, 10, 0, 0, 0, 10, 0, 'h1234), 0, 0);
    repeat (12) applyStimulus(0, nullTri, 0, 0);
    applyStimulus(0, nullTri, 1, 0);
    repeat (2) applyStimulus(0, nullTri, 0, 0);

    // Back-to-back pushes against a stalled core fill the FIFO.
    for (int i = 0; i < 8; i++) applyStimulus(1, mkTri(i, 0, 0, i + 5, 1, 0, i, 7, 1, i + 'h100), 0, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, nullTri, 1, 0);
      applyStimulus(0, nullTri, 0, 0);
      applyStimulus(0, nullTri, 0, 0);
    end

    // eoc held high across issue and wait.
    applyStimulus(1, mkTri(1, 1, 0, 9, 2, 0, 3, 8, 0, 'h55), 1, 0);
    repeat (5) applyStimulus(0, nullTri, 1, 0);
    applyStimulus(0, nullTri, 0, 0);

    // Reset while waiting with two buffered triangles.
    for (int i = 0; i < 3; i++) applyStimulus(1, mkTri(2, i, 0, 20, 3, 0, 4, 30, 0, i + 'h77), 0, 0);
    repeat (3) applyStimulus(0, nullTri, 0, 0);
    applyStimulus(0, nullTri, 0, 1);
    repeat (3) applyStimulus(0, nullTri, 1, 0);

    // Collinear triangle followed by a proper one.
    applyStimulus(1, mkTri(0, 0, 0, 5, 5, 0, 10, 10, 0, 'h0bad), 0, 0);
    applyStimulus(1, mkTri(0, 0, 0, 10, 0, 0, 0, 10, 0, 'h0600d), 0, 0);
    repeat (6) applyStimulus(0, nullTri, 0, 0);
    applyStimulus(0, nullTri, 1, 0);
    repeat (6) applyStimulus(0, nullTri, 1, 0);

    // Random traffic with varying push and eoc densities and rare resets.
    for (int phase = 0; phase < 4; phase++) begin
      for (int i = 0; i < 250; i++) begin
        applyStimulus($urandom_range(0, 3) < (phase + 1),
                      randTri(),
                      $urandom_range(0, 7) < (2 * phase + 1),
                      $urandom_range(0, 149) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
